// File: rtl/ram_arb_pkg.sv
// Shared types and the round-robin search used by ram_arbiter and other bus arbiters.
// Supports up to RR_MAX requesters.
package ram_arb_pkg;

    typedef enum logic {Idle, Owned} ArbState;

    localparam int RR_MAX = 8;

    // Returns the first set bit of valid searching upward from last+1 with wrap,
    // or last itself when nothing is valid.
    function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int last, input int nreq);
        int  j;
        bit  found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            j = (last + k) % nreq;
            if ((k <= nreq) && !found && valid[j[2:0]]) begin
                rr_pick = j;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational rotate-and-priority-encode: next valid requester after the last winner.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          found
);
    import ram_arb_pkg::*;

    always_comb begin
        idx   = IW'(rr_pick(RR_MAX'(valid), int'(last), N));
        found = |valid;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin, burst-limited arbiter sharing a 1-cycle-latency single-port RAM.
// Optional owner lock (bypasses the burst limit) is built when RAM_ARB_LOCK_EN is defined.
//
//   state | meaning
//   Idle  | no owner; grant goes purely round-robin
//   Owned | owner keeps the grant while valid and under the burst limit (or locked)
module ram_arbiter #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [NREQ-1:0]        req_lock,
`endif
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata
);
    import ram_arb_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    ArbState           state, next_state;
    logic [IW-1:0]     owner, rr_last, rr_idx, grant, rsp_tag;
    logic [BW-1:0]     burst_cnt;
    logic              rr_found, keep_owner, lock_hold, accept, rsp_pend;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q, sel_wdata;

    rr_picker #(.N(NREQ), .IW(IW)) u_rr_picker (
        .valid (req_valid),
        .last  (rr_last),
        .idx   (rr_idx),
        .found (rr_found)
    );

`ifdef RAM_ARB_LOCK_EN
    assign lock_hold = req_lock[owner];
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        keep_owner = (state == Owned) && req_valid[owner] &&
                     ((burst_cnt < BW'(MAX_BURST)) || lock_hold);
        grant      = keep_owner ? owner : rr_idx;
        accept     = keep_owner || rr_found;
        req_ready  = '0;
        if (accept) req_ready[grant] = 1'b1;
        sel_addr   = req_addr[int'(grant)*ADDR_W +: ADDR_W];
        sel_wdata  = req_wdata[int'(grant)*DATA_W +: DATA_W];
    end

    // Address/data park on the last accepted beat so idle cycles do not toggle the macro pins.
    always_comb begin
        ram_en    = accept;
        ram_we    = accept && req_we[grant];
        ram_addr  = accept ? sel_addr  : addr_q;
        ram_wdata = accept ? sel_wdata : wdata_q;
        rsp_valid = '0;
        if (rsp_pend) rsp_valid[rsp_tag] = 1'b1;
        rsp_rdata = ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= Idle;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            Idle:    if (accept)  next_state = Owned;
            Owned:   if (!accept) next_state = Idle;
            default: next_state = Idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= '0;
            rr_last   <= IW'(NREQ - 1);
            burst_cnt <= '0;
            rsp_pend  <= 1'b0;
            rsp_tag   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_pend <= accept && !req_we[grant];
            rsp_tag  <= grant;
            if (accept) begin
                owner   <= grant;
                rr_last <= grant;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                if ((state == Owned) && (grant == owner)) begin
                    // Locked owners saturate; an expired sole owner restarts its burst.
                    if (burst_cnt < BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
                    else if (!lock_hold)            burst_cnt <= BW'(1);
                end else begin
                    burst_cnt <= BW'(1);
                end
            end else begin
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected grants are constants, read data comes from a shadow memory.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_lock = '0;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    typedef struct {
        logic [1:0]  tag;
        logic [15:0] data;
        int          stamp;
    } rsp_t;
    rsp_t sb[$];

    logic [15:0] shadow [256];
    logic [15:0] ram    [256];
    bit          ram_wr [256];

    ram_arbiter #(.NREQ(2), .ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef RAM_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {8'hA0, a};
    endfunction

    // RAM macro model: 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr[7:0]]    <= ram_wdata;
                ram_wr[ram_addr[7:0]] <= 1'b1;
            end else begin
                ram_rdata <= ram_wr[ram_addr[7:0]] ? ram[ram_addr[7:0]] : init_val(ram_addr[7:0]);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Responses are due exactly one cycle after the read was accepted.
    always @(negedge clk) begin
        rsp_t e;
        if (sb.size() > 0 && sb[0].stamp < cyc_cnt) begin
            e = sb.pop_front();
            check("rsp_tag", rsp_valid, e.tag);
            check("rsp_data", rsp_rdata, e.data);
        end else if (rsp_valid != 0) begin
            check("rsp_unexp", rsp_valid, 0);
        end
    end

    task automatic drive(input int i, input bit v, input bit we = 1'b0,
                         input logic [15:0] a = 16'h0, input logic [15:0] d = 16'h0);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*16 +: 16]  = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic beat(input logic [1:0] exp_rdy, input string tag, input bit track = 1'b1);
        logic [15:0] a;
        @(negedge clk);
        check(tag, req_ready, exp_rdy);
        check({tag, "_en"}, ram_en, |exp_rdy);
        if (exp_rdy == 2'b00) check({tag, "_we0"}, ram_we, 0);
        for (int i = 0; i < 2; i++) begin
            if (exp_rdy[i]) begin
                a = req_addr[i*16 +: 16];
                check({tag, "_we"}, ram_we, req_we[i]);
                check({tag, "_addr"}, ram_addr, a);
                if (req_we[i]) shadow[a[7:0]] = req_wdata[i*16 +: 16];
                else if (track) sb.push_back('{2'(1 << i), shadow[a[7:0]], cyc_cnt});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [10];
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_en", ram_en, 0);
        check("rst_rsp", rsp_valid, 0);
        @(posedge clk);
        #1;

        // single read of 0x0010, then idle with a different parked address
        drive(0, 1, 0, 16'h0010);
        beat(2'b01, "rd0");
        drive(0, 0, 0, 16'h0055);
        beat(2'b00, "idle");
        check("hold_addr", ram_addr, 16'h0010);

        // both requesters streaming reads: bursts of four
        do_reset();
        seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        drive(0, 1, 0, 16'h0030);
        drive(1, 1, 0, 16'h0040);
        for (int k = 0; k < 10; k++) beat(seq[k], "burst");
        drive(0, 0);
        drive(1, 0);
        beat(2'b00, "burst_end");

        // write by 1 then read of same address by 0
        drive(1, 1, 1, 16'h0020, 16'h1234);
        beat(2'b10, "wr1");
        drive(1, 0);
        drive(0, 1, 0, 16'h0020);
        beat(2'b01, "rd_after_wr");
        drive(0, 0);
        beat(2'b00, "wr_end");

        // owner drops after two beats; requester 1 takes over with a fresh burst
        do_reset();
        drive(0, 1, 0, 16'h0050);
        beat(2'b01, "drop_a");
        beat(2'b01, "drop_b");
        drive(0, 0);
        drive(1, 1, 0, 16'h0060);
        beat(2'b10, "drop_sw");
        drive(0, 1, 0, 16'h0050);
        beat(2'b10, "drop_c");
        beat(2'b10, "drop_d");
        beat(2'b10, "drop_e");
        beat(2'b01, "drop_f");
        drive(0, 0);
        drive(1, 0);
        beat(2'b00, "drop_end");

        // sole owner past the limit is re-granted and restarts its count
        do_reset();
        drive(0, 1, 0, 16'h0070);
        for (int k = 0; k < 6; k++) beat(2'b01, "solo");
        drive(1, 1, 0, 16'h0080);
        beat(2'b01, "solo_g");
        beat(2'b01, "solo_h");
        beat(2'b10, "solo_sw");
        drive(0, 0);
        drive(1, 0);
        beat(2'b00, "solo_end");

        // reset right after a read accept discards the response
        do_reset();
        drive(0, 1, 0, 16'h0090);
        beat(2'b01, "rst_rd", 1'b0);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("rst_flush", rsp_valid, 0);
        check("rst_rdy0", req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1, 0, 16'h0090);
        drive(1, 1, 0, 16'h00A0);
        beat(2'b01, "post_rst");
        drive(0, 0);
        drive(1, 0);
        beat(2'b00, "post_rst_end");

`ifdef RAM_ARB_LOCK_EN
        do_reset();
        drive(0, 1, 0, 16'h00B0);
        drive(1, 1, 0, 16'h00C0);
        req_lock = 2'b11;
        for (int k = 0; k < 6; k++) beat(2'b01, "lock");
        req_lock = 2'b00;
        beat(2'b10, "lock_rel");
        drive(0, 0);
        drive(1, 0);
        beat(2'b00, "lock_end");
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
